// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// ALU-op and mux select codes, and the control word driven to the datapath.
package multicycle_pkg;

  localparam int unsigned STATE_BITS = 4;
  localparam int unsigned OP_W       = 6;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] alu_operation;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       illegal_op;
  } ctrl_t;

  // State following DECODE; unsupported opcodes fall back to FETCH.
  function automatic state_t decode_next(input logic [OP_W-1:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:           nxt = S_MEMADR;
      OP_RTYPE:               nxt = S_EXECUTE;
      OP_BEQ:                 nxt = S_BRANCH;
      OP_ADDI, OP_ORI, OP_LUI: nxt = S_IMMEX;
      OP_J:                   nxt = S_JUMP;
      default:                nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic is_imm_logic(input logic [OP_W-1:0] op);
    return (op == OP_ORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_dec.sv
// Combinational control-word decode from the current state and the opcode
// latched in DECODE.
module multicycle_ctrl_out_dec
  import multicycle_pkg::*;
(
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_opcode,
  input  logic            i_illegal,
  input  logic            i_mem_ok,
  output ctrl_t           o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = i_mem_ok;
        o_ctrl.pc_write  = i_mem_ok;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        o_ctrl.alu_src_b  = SRCB_BOFF;
        o_ctrl.illegal_op = i_illegal;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.i_or_d   = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_operation = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_operation = ALUOP_SUB;
        o_ctrl.branch        = 1'b1;
        o_ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_IMMEX: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_IMM;
        o_ctrl.alu_operation = is_imm_logic(i_opcode) ? ALUOP_IMM : ALUOP_ADD;
        o_ctrl.ext_zero      = is_imm_logic(i_opcode);
      end
      S_IMMWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register, opcode
// latch and next-state logic. Define MULTICYCLE_MEM_WAIT_EN to stall memory
// states on mem_ready.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic [1:0]         alu_operation,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [1:0]         pc_src,
  output logic               pc_write,
  output logic               branch,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_read,
  output logic               i_or_d,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t          r_state;
  logic [OP_W-1:0] r_opcode;
  logic            w_mem_ok;
  logic            w_illegal;
  ctrl_t           w_ctrl;
  ctrl_t           w_ctrl_out;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  assign w_illegal = (decode_next(opcode) == S_FETCH);

  // Opcode is captured in DECODE so later states never see the live IR field.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
    end else begin
      case (r_state)
        S_FETCH:   if (w_mem_ok) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= opcode;
          r_state  <= decode_next(opcode);
        end
        S_MEMADR:  r_state <= (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (w_mem_ok) r_state <= S_MEMWB;
        S_MEMWR:   if (w_mem_ok) r_state <= S_FETCH;
        S_EXECUTE: r_state <= S_ALUWB;
        S_IMMEX:   r_state <= S_IMMWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  multicycle_ctrl_out_dec u_out_dec (
    .i_state   (r_state),
    .i_opcode  (r_opcode),
    .i_illegal (w_illegal),
    .i_mem_ok  (w_mem_ok),
    .o_ctrl    (w_ctrl)
  );

  // Reset masks the control word immediately, so no strobe fires in the reset cycle.
  assign w_ctrl_out = reset ? '0 : w_ctrl;
  assign state      = reset ? STATE_W'(S_FETCH) : STATE_W'(r_state);

  assign alu_operation = w_ctrl_out.alu_operation;
  assign alu_src_a     = w_ctrl_out.alu_src_a;
  assign alu_src_b     = w_ctrl_out.alu_src_b;
  assign ext_zero      = w_ctrl_out.ext_zero;
  assign pc_src        = w_ctrl_out.pc_src;
  assign pc_write      = w_ctrl_out.pc_write;
  assign branch        = w_ctrl_out.branch;
  assign ir_write      = w_ctrl_out.ir_write;
  assign reg_write     = w_ctrl_out.reg_write;
  assign mem_write     = w_ctrl_out.mem_write;
  assign mem_read      = w_ctrl_out.mem_read;
  assign i_or_d        = w_ctrl_out.i_or_d;
  assign mem_to_reg    = w_ctrl_out.mem_to_reg;
  assign reg_dst       = w_ctrl_out.reg_dst;
  assign illegal_op    = w_ctrl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction table, randomized
// instruction stream against a per-instruction step model, and reset/stall sequences.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

`ifdef MULTICYCLE_MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_src;
  logic       pc_write, branch, ir_write, reg_write, mem_write, mem_read;
  logic       i_or_d, mem_to_reg, reg_dst, illegal_op;
  logic [3:0] state;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_operation(alu_operation), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_src(pc_src), .pc_write(pc_write), .branch(branch),
    .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .mem_read(mem_read), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       ez;
    logic [1:0] ps;
    logic       pcw, br, irw, rw, mw, mr, iod, m2r, rd, ill;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    int         cpi;
    int         rw;
    int         mw;
    int         ill;
  } vec_t;

  obs_t   dut_obs;
  state_t seq_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  always_comb begin
    dut_obs = '{aop: alu_operation, sa: alu_src_a, sb: alu_src_b, ez: ext_zero,
                ps: pc_src, pcw: pc_write, br: branch, irw: ir_write,
                rw: reg_write, mw: mem_write, mr: mem_read, iod: i_or_d,
                m2r: mem_to_reg, rd: reg_dst, ill: illegal_op};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b001101, 6'b001111, 6'b000010};
  endfunction

  // Ordered list of steps an instruction walks through, without stalls.
  task automatic build_seq(input logic [5:0] op);
    seq_q = {};
    seq_q.push_back(S_FETCH);
    seq_q.push_back(S_DECODE);
    case (op)
      6'b100011: begin seq_q.push_back(S_MEMADR); seq_q.push_back(S_MEMRD); seq_q.push_back(S_MEMWB); end
      6'b101011: begin seq_q.push_back(S_MEMADR); seq_q.push_back(S_MEMWR); end
      6'b000000: begin seq_q.push_back(S_EXECUTE); seq_q.push_back(S_ALUWB); end
      6'b000100: seq_q.push_back(S_BRANCH);
      6'b001000, 6'b001101, 6'b001111: begin seq_q.push_back(S_IMMEX); seq_q.push_back(S_IMMWB); end
      6'b000010: seq_q.push_back(S_JUMP);
      default: ;
    endcase
  endtask

  function automatic obs_t expect_word(input state_t s, input logic [5:0] op, input logic rdy);
    obs_t e = '0;
    bit logic_imm = (op == 6'b001101) || (op == 6'b001111);
    if (s == S_FETCH) begin
      e.mr = 1'b1; e.sb = 2'b01;
      e.irw = WAIT ? rdy : 1'b1;
      e.pcw = WAIT ? rdy : 1'b1;
    end
    if (s == S_DECODE) begin e.sb = 2'b11; e.ill = !op_legal(op); end
    if (s == S_MEMADR) begin e.sa = 1'b1; e.sb = 2'b10; end
    if (s == S_MEMRD)  begin e.iod = 1'b1; e.mr = 1'b1; end
    if (s == S_MEMWB)  begin e.rw = 1'b1; e.m2r = 1'b1; end
    if (s == S_MEMWR)  begin e.iod = 1'b1; e.mw = 1'b1; end
    if (s == S_EXECUTE) begin e.sa = 1'b1; e.aop = 2'b10; end
    if (s == S_ALUWB)  begin e.rw = 1'b1; e.rd = 1'b1; end
    if (s == S_BRANCH) begin e.sa = 1'b1; e.aop = 2'b01; e.br = 1'b1; e.ps = 2'b01; end
    if (s == S_IMMEX) begin
      e.sa = 1'b1; e.sb = 2'b10;
      e.aop = logic_imm ? 2'b11 : 2'b00;
      e.ez = logic_imm;
    end
    if (s == S_IMMWB) e.rw = 1'b1;
    if (s == S_JUMP)  begin e.pcw = 1'b1; e.ps = 2'b10; end
    return e;
  endfunction

  // Called at FETCH; returns at the following FETCH.
  task automatic run_instr(input logic [5:0] op, input bit rnd, output int cyc,
                           output int rw, output int mw, output int ill);
    int idx = 0;
    int stalls = 0;
    state_t s;
    build_seq(op);
    cyc = 0; rw = 0; mw = 0; ill = 0;
    while (idx < seq_q.size()) begin
      s = seq_q[idx];
      opcode = (s == S_DECODE) ? op : 6'($urandom);
      mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalls >= 3) mem_ready = 1'b1;
      #1;
      check("state", 32'(state), 32'(s));
      check("ctrl", 32'(dut_obs), 32'(expect_word(s, op, mem_ready)));
      if (state != 4'(S_FETCH)) cyc++;
      rw  += 32'(reg_write);
      mw  += 32'(mem_write);
      ill += 32'(illegal_op);
      if (WAIT && (s inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem_ready) stalls++;
      else begin idx++; stalls = 0; end
      @(posedge clk); #1;
    end
    cyc += 1;
  endtask

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c, rw, mw, il, pcw_cnt;
    logic [5:0] op;
    logic [5:0] legal_ops[8];

    tbl[0] = '{6'b100011, 5, 1, 0, 0};
    tbl[1] = '{6'b101011, 4, 0, 1, 0};
    tbl[2] = '{6'b000000, 4, 1, 0, 0};
    tbl[3] = '{6'b000100, 3, 0, 0, 0};
    tbl[4] = '{6'b001000, 4, 1, 0, 0};
    tbl[5] = '{6'b001101, 4, 1, 0, 0};
    tbl[6] = '{6'b001111, 4, 1, 0, 0};
    tbl[7] = '{6'b000010, 3, 0, 0, 0};
    tbl[8] = '{6'b111111, 2, 0, 0, 1};
    tbl[9] = '{6'b000011, 2, 0, 0, 1};
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                  6'b001000, 6'b001101, 6'b001111, 6'b000010};

    reset = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(S_FETCH));
    check("reset_ctrl", 32'(dut_obs), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, 1'b0, c, rw, mw, il);
      check("cpi", 32'(c), 32'(tbl[i].cpi));
      check("reg_write_cnt", 32'(rw), 32'(tbl[i].rw));
      check("mem_write_cnt", 32'(mw), 32'(tbl[i].mw));
      check("illegal_cnt", 32'(il), 32'(tbl[i].ill));
    end

    // Reset during MEMWR of sw must suppress the write and abort the store.
    opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #1;
    check("sw_memwr_state", 32'(state), 32'(S_MEMWR));
    check("sw_memwr_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_write", 32'(mem_write), 32'd0);
    check("rst_mid_state", 32'(state), 32'(S_FETCH));
    check("rst_mid_ctrl", 32'(dut_obs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_state", 32'(state), 32'(S_FETCH));
    check("post_rst_mem_read", 32'(mem_read), 32'd1);

    // FETCH with mem_ready low for three cycles.
    pcw_cnt = 0;
    opcode = 6'b000000;
    mem_ready = 1'b0;
    #1;
`ifdef MULTICYCLE_MEM_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      check("stall_state", 32'(state), 32'(S_FETCH));
      check("stall_irw", 32'(ir_write), 32'd0);
      check("stall_mem_read", 32'(mem_read), 32'd1);
      pcw_cnt += 32'(pc_write);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #1;
    check("ready_irw", 32'(ir_write), 32'd1);
    pcw_cnt += 32'(pc_write);
    check("pc_write_once", 32'(pcw_cnt), 32'd1);
`else
    check("noready_pcw", 32'(pc_write), 32'd1);
    check("noready_irw", 32'(ir_write), 32'd1);
`endif
    @(posedge clk); #1;
    check("after_fetch_state", 32'(state), 32'(S_DECODE));
    opcode = 6'b111111; mem_ready = 1'b1;
    #1;
    check("decode_illegal", 32'(illegal_op), 32'd1);
    @(posedge clk); #1;
    check("illegal_back_fetch", 32'(state), 32'(S_FETCH));

    // Random instruction stream; opcode is garbage outside DECODE.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 7)];
      run_instr(op, 1'b1, c, rw, mw, il);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
